// File: rtl/dp_pkg.sv
// Shared types and arithmetic helpers for the dot-product engine.
// Widths are derived from the operand width and lane count by constant functions.
package dp_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int CALC_WIDTH         = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } dp_state_t;

    typedef struct packed {
        logic signed [CALC_WIDTH-1:0] value;
        logic                         ovf;
    } sat_add_t;

    function automatic int prod_width(input int data_width);
        return 2 * data_width;
    endfunction

    function automatic int sum_width(input int data_width, input int lanes);
        return 2 * data_width + $clog2(lanes);
    endfunction

    // Adds in a wide domain, flags overflow of an acc_width-bit signed result,
    // then either clamps or wraps back into that range.
    function automatic sat_add_t sat_add(input logic signed [CALC_WIDTH-1:0] acc,
                                         input logic signed [CALC_WIDTH-1:0] addend,
                                         input int acc_width,
                                         input logic sat);
        logic signed [CALC_WIDTH-1:0] sum;
        logic signed [CALC_WIDTH-1:0] max_v;
        logic signed [CALC_WIDTH-1:0] min_v;
        sat_add_t r;
        sum   = acc + addend;
        max_v = (64'sd1 <<< (acc_width - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (acc_width - 1));
        r.ovf = (sum > max_v) || (sum < min_v);
        if (r.ovf && sat)
            r.value = (sum > max_v) ? max_v : min_v;
        else
            r.value = (sum <<< (CALC_WIDTH - acc_width)) >>> (CALC_WIDTH - acc_width);
        return r;
    endfunction

endpackage

// File: rtl/dp_adder_tree.sv
// Signed reduction of LANES packed products into one registered sum.
// flush drops the in-flight value without touching the held sum.
module dp_adder_tree
    import dp_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int LANES      = 4
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              flush,
    input  logic                                              in_valid,
    input  logic [LANES*prod_width(DATA_WIDTH)-1:0]           products,
    output logic                                              out_valid,
    output logic signed [sum_width(DATA_WIDTH, LANES)-1:0]    sum
);
    localparam int PW = prod_width(DATA_WIDTH);
    localparam int SW = sum_width(DATA_WIDTH, LANES);

    logic signed [SW-1:0] tree_sum;

    // NOTE: blocking assignments are correct inside always_comb; the running
    // sum is a chain of adders, not state, and the default first prevents a latch.
    always_comb begin
        tree_sum = '0;
        for (int i = 0; i < LANES; i++)
            tree_sum = tree_sum + SW'(signed'(products[i*PW +: PW]));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
        end else begin
            out_valid <= in_valid && !flush;
            if (in_valid)
                sum <= tree_sum;
        end
    end

endmodule

// File: rtl/dot_product_engine.sv
// Streams cfg_beats beats of LANES signed products through a 3-stage pipeline
// (products, adder tree, accumulate) and hands one dot product to the consumer.
module dot_product_engine
    import dp_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int LANES      = 4,
    parameter int ACC_WIDTH  = 32,
    parameter int BEAT_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [BEAT_WIDTH-1:0]       cfg_beats,
    input  logic                        sat_en,
    input  logic                        abort,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES*DATA_WIDTH-1:0] in_a,
    input  logic [LANES*DATA_WIDTH-1:0] in_b,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ACC_WIDTH-1:0]        out_result,
    output logic                        out_ovf,
    output logic                        busy
);
    localparam int PW = prod_width(DATA_WIDTH);
    localparam int SW = sum_width(DATA_WIDTH, LANES);

    dp_state_t                    state;
    logic [BEAT_WIDTH-1:0]        remaining;
    logic                         sat_q;
    logic                         ovf_q;
    logic signed [ACC_WIDTH-1:0]  acc;
    logic [LANES*PW-1:0]          lane_prod;
    logic [LANES*PW-1:0]          prod_q;
    logic                         s1_valid;
    logic                         s2_valid;
    logic                         beat_fire;
    logic signed [SW-1:0]         tree_sum;
    logic signed [CALC_WIDTH-1:0] acc_ext;
    logic signed [CALC_WIDTH-1:0] sum_ext;
    sat_add_t                     add_r;
    logic                         unused_hi;

    assign in_ready   = (state == ST_ACCUM) && (remaining != '0);
    assign beat_fire  = in_valid && in_ready;
    assign out_valid  = (state == ST_OUT);
    assign busy       = (state != ST_IDLE);
    assign out_result = acc;
    assign out_ovf    = ovf_q;

    always_comb begin
        lane_prod = '0;
        for (int i = 0; i < LANES; i++)
            lane_prod[i*PW +: PW] = PW'(signed'(in_a[i*DATA_WIDTH +: DATA_WIDTH]))
                                  * PW'(signed'(in_b[i*DATA_WIDTH +: DATA_WIDTH]));
    end

    // NOTE: every register here uses <= so all stages sample the pre-edge
    // values of their neighbours; blocking would collapse the pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            prod_q   <= '0;
        end else begin
            s1_valid <= beat_fire && !abort;
            if (beat_fire)
                prod_q <= lane_prod;
        end
    end

    dp_adder_tree #(
        .DATA_WIDTH (DATA_WIDTH),
        .LANES      (LANES)
    ) u_adder_tree (
        .clk       (clk),
        .rst       (rst),
        .flush     (abort),
        .in_valid  (s1_valid),
        .products  (prod_q),
        .out_valid (s2_valid),
        .sum       (tree_sum)
    );

    // Accumulation is done in a wide domain so sums wider than the
    // accumulator still overflow, clamp and wrap correctly.
    always_comb begin
        acc_ext = {{(CALC_WIDTH-ACC_WIDTH){acc[ACC_WIDTH-1]}}, acc};
        sum_ext = {{(CALC_WIDTH-SW){tree_sum[SW-1]}}, tree_sum};
        add_r   = sat_add(acc_ext, sum_ext, ACC_WIDTH, sat_q);
    end

    assign unused_hi = ^add_r.value[CALC_WIDTH-1:ACC_WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            remaining <= '0;
            sat_q     <= 1'b0;
            acc       <= '0;
            ovf_q     <= 1'b0;
        end else if (abort) begin
            state     <= ST_IDLE;
            remaining <= '0;
        end else begin
            if (s2_valid) begin
                acc   <= add_r.value[ACC_WIDTH-1:0];
                ovf_q <= ovf_q | add_r.ovf;
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        remaining <= cfg_beats;
                        sat_q     <= sat_en;
                        acc       <= '0;
                        ovf_q     <= 1'b0;
                        state     <= (cfg_beats == '0) ? ST_OUT : ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (beat_fire) begin
                        remaining <= remaining - BEAT_WIDTH'(1);
                        if (remaining == BEAT_WIDTH'(1))
                            state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!s1_valid && !s2_valid)
                        state <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dot_product_engine.sv
// Bench for dot_product_engine: directed scenarios plus random vectors checked
// against an arithmetic dot-product model, on a 32-bit and a 16-bit accumulator.
module tb_dot_product_engine;

    localparam int DW    = 8;
    localparam int LANES = 4;
    localparam int BW    = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [BW-1:0]     cfg_beats = '0;
    logic              sat_en = 1'b0;
    logic              abort = 1'b0;
    logic              in_valid = 1'b0;
    logic [LANES*DW-1:0] in_a = '0;
    logic [LANES*DW-1:0] in_b = '0;
    logic              out_ready = 1'b0;

    logic              in_ready, out_valid, out_ovf, busy;
    logic [31:0]       out_result;
    logic              in_ready16, out_valid16, out_ovf16, busy16;
    logic [15:0]       out_result16;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] beat_a[$];
    logic [31:0] beat_b[$];

    logic [31:0] r_res;
    logic        r_ovf;
    logic [15:0] r_res16;
    logic        r_ovf16;
    int          r_latency;
    int          r_accept;
    logic        r_ready_after;
    bit          r_unstable;
    bit          r_idle_after;

    always #5 clk = ~clk;

    dot_product_engine #(.DATA_WIDTH(DW), .LANES(LANES), .ACC_WIDTH(32), .BEAT_WIDTH(BW)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_beats(cfg_beats), .sat_en(sat_en),
        .abort(abort), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_ovf(out_ovf), .busy(busy)
    );

    dot_product_engine #(.DATA_WIDTH(DW), .LANES(LANES), .ACC_WIDTH(16), .BEAT_WIDTH(BW)) dut16 (
        .clk(clk), .rst(rst), .start(start), .cfg_beats(cfg_beats), .sat_en(sat_en),
        .abort(abort), .in_valid(in_valid), .in_ready(in_ready16), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid16), .out_ready(out_ready), .out_result(out_result16),
        .out_ovf(out_ovf16), .busy(busy16)
    );

    function automatic longint beat_dot(input logic [31:0] a, input logic [31:0] b);
        longint s = 0;
        byte sa, sb;
        for (int i = 0; i < LANES; i++) begin
            sa = a[i*DW +: DW];
            sb = b[i*DW +: DW];
            s += longint'(sa) * longint'(sb);
        end
        return s;
    endfunction

    // Sum of per-beat dot products over the queued beats; out-of-range partial
    // sums set ovf and are clamped or wrapped modulo 2^w.
    function automatic longint model_dot(input int n, input bit sat, input int w, output bit ovf);
        longint acc = 0;
        longint hi = (longint'(1) <<< (w - 1)) - 1;
        longint lo = -hi - 1;
        longint m = longint'(1) <<< w;
        longint r;
        ovf = 0;
        for (int k = 0; k < n; k++) begin
            acc += beat_dot(beat_a[k], beat_b[k]);
            if (acc > hi || acc < lo) begin
                ovf = 1;
                if (sat) acc = (acc > hi) ? hi : lo;
                else begin
                    r = (acc - lo) % m;
                    if (r < 0) r += m;
                    acc = r + lo;
                end
            end
        end
        return acc;
    endfunction

    task automatic fill_random(input int n);
        beat_a.delete();
        beat_b.delete();
        for (int k = 0; k < n; k++) begin
            beat_a.push_back($urandom);
            beat_b.push_back($urandom);
        end
    endtask

    // Runs one whole operation; mode 0 = no bubbles, 1 = valid every other
    // cycle, 2 = random bubbles. Leaves observations in the r_* variables.
    task automatic run_op(input int n, input bit sat, input int mode, input int hold,
                          input bit start_with_ready);
        int idx = 0;
        int cyc = 0;
        bit fire;
        start = 1'b1; cfg_beats = BW'(n); sat_en = sat;
        @(posedge clk); #1;
        start = 1'b0;
        while (idx < n && cyc < 1000) begin
            case (mode)
                0: in_valid = 1'b1;
                1: in_valid = (cyc % 2 == 0);
                default: in_valid = ($urandom_range(0, 3) != 0);
            endcase
            in_a = beat_a[idx];
            in_b = beat_b[idx];
            fire = in_valid && in_ready;
            @(posedge clk); #1;
            if (fire) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        in_a = $urandom;
        in_b = $urandom;
        r_accept = cyc;
        r_ready_after = in_ready;
        r_latency = (n == 0) ? 0 : 1;
        while (!out_valid && r_latency < 200) begin
            @(posedge clk); #1;
            r_latency++;
        end
        r_res = out_result; r_ovf = out_ovf;
        r_res16 = out_result16; r_ovf16 = out_ovf16;
        r_unstable = 0;
        repeat (hold) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || out_result !== r_res || out_ovf !== r_ovf) r_unstable = 1;
        end
        out_ready = 1'b1;
        if (start_with_ready) begin
            start = 1'b1; cfg_beats = BW'(5);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        start = 1'b0;
        r_idle_after = !busy && !out_valid;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        vectors++; if (out_result !== 32'd0) begin miscompares++; $display("FAIL reset_out_result: got %h want 0", out_result); end
        vectors++; if (out_ovf !== 1'b0) begin miscompares++; $display("FAIL reset_out_ovf: got %b want 0", out_ovf); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        beat_a = '{32'h04030201, 32'hFFFFFFFF};
        beat_b = '{32'h08070605, 32'hFFFFFFFF};
        run_op(2, 0, 0, 0, 0);
        vectors++; if (r_res !== 32'd74) begin miscompares++; $display("FAIL basic_result: got %0d want 74", $signed(r_res)); end
        vectors++; if (r_ovf !== 1'b0) begin miscompares++; $display("FAIL basic_ovf: got %b want 0", r_ovf); end
        vectors++; if (r_latency != 4) begin miscompares++; $display("FAIL basic_latency: got %0d want 4", r_latency); end
        vectors++; if (r_accept != 2) begin miscompares++; $display("FAIL basic_accept_cycles: got %0d want 2", r_accept); end
        vectors++; if (r_res16 !== 16'd74) begin miscompares++; $display("FAIL basic_result16: got %0d want 74", $signed(r_res16)); end
    endtask

    task automatic test_bubbles_backpressure();
        longint e;
        bit eo;
        logic [31:0] e32;
        fill_random(3);
        e = model_dot(3, 0, 32, eo);
        e32 = e[31:0];
        run_op(3, 0, 1, 5, 1);
        vectors++; if (r_res !== e32) begin miscompares++; $display("FAIL bubble_result: got %0d want %0d", $signed(r_res), $signed(e32)); end
        vectors++; if (r_ovf !== eo) begin miscompares++; $display("FAIL bubble_ovf: got %b want %b", r_ovf, eo); end
        vectors++; if (r_ready_after !== 1'b0) begin miscompares++; $display("FAIL bubble_ready_drop: got %b want 0", r_ready_after); end
        vectors++; if (r_accept != 5) begin miscompares++; $display("FAIL bubble_accept_cycles: got %0d want 5", r_accept); end
        vectors++; if (r_unstable !== 1'b0) begin miscompares++; $display("FAIL bubble_out_stable: got unstable=%b want 0", r_unstable); end
        vectors++; if (r_idle_after !== 1'b1) begin miscompares++; $display("FAIL bubble_idle_after_ready: got %b want 1 (start must be ignored)", r_idle_after); end
        vectors++; if (r_latency != 4) begin miscompares++; $display("FAIL bubble_latency: got %0d want 4", r_latency); end
    endtask

    task automatic test_saturation();
        beat_a = '{32'h80808080, 32'h80808080, 32'h80808080};
        beat_b = '{32'h80808080, 32'h80808080, 32'h80808080};
        run_op(3, 1, 0, 0, 0);
        vectors++; if (r_res16 !== 16'h7FFF) begin miscompares++; $display("FAIL sat16_result: got %0d want 32767", $signed(r_res16)); end
        vectors++; if (r_ovf16 !== 1'b1) begin miscompares++; $display("FAIL sat16_ovf: got %b want 1", r_ovf16); end
        vectors++; if (r_res !== 32'd196608) begin miscompares++; $display("FAIL sat32_result: got %0d want 196608", $signed(r_res)); end
        vectors++; if (r_ovf !== 1'b0) begin miscompares++; $display("FAIL sat32_ovf: got %b want 0", r_ovf); end
        run_op(3, 0, 0, 0, 0);
        vectors++; if (r_res16 !== 16'd0) begin miscompares++; $display("FAIL wrap16_result: got %0d want 0", $signed(r_res16)); end
        vectors++; if (r_ovf16 !== 1'b1) begin miscompares++; $display("FAIL wrap16_ovf: got %b want 1", r_ovf16); end
    endtask

    task automatic test_zero_beats();
        run_op(0, 0, 0, 0, 0);
        vectors++; if (r_latency != 0) begin miscompares++; $display("FAIL zero_latency: got %0d extra cycles want 0", r_latency); end
        vectors++; if (r_res !== 32'd0) begin miscompares++; $display("FAIL zero_result: got %0d want 0", $signed(r_res)); end
        vectors++; if (r_ovf !== 1'b0) begin miscompares++; $display("FAIL zero_ovf: got %b want 0", r_ovf); end
        vectors++; if (r_ready_after !== 1'b0) begin miscompares++; $display("FAIL zero_in_ready: got %b want 0", r_ready_after); end
    endtask

    task automatic test_abort();
        start = 1'b1; cfg_beats = BW'(4); sat_en = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1; in_a = 32'h7F7F7F7F; in_b = 32'h7F7F7F7F;
        @(posedge clk); #1;
        in_a = 32'h11111111; in_b = 32'h22222222;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; in_valid = 1'b0;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL abort_out_valid: got %b want 0", out_valid); end
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL abort_in_ready: got %b want 0", in_ready); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %b want 0", busy); end
        repeat (3) @(posedge clk);
        #1;
        beat_a = '{32'h02020202};
        beat_b = '{32'h02020202};
        run_op(1, 0, 0, 0, 0);
        vectors++; if (r_res !== 32'd16) begin miscompares++; $display("FAIL abort_next_result: got %0d want 16", $signed(r_res)); end
        vectors++; if (r_ovf !== 1'b0) begin miscompares++; $display("FAIL abort_next_ovf: got %b want 0", r_ovf); end
    endtask

    task automatic test_reset_mid_op();
        int wait_cyc = 0;
        longint e;
        bit eo;
        logic [31:0] e32;
        start = 1'b1; cfg_beats = BW'(1);
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1; in_a = 32'h01010101; in_b = 32'h01010101;
        @(posedge clk); #1;
        in_valid = 1'b0;
        while (!out_valid && wait_cyc < 20) begin
            @(posedge clk); #1;
            wait_cyc++;
        end
        vectors++; if (out_valid !== 1'b1 || out_result !== 32'd4) begin miscompares++; $display("FAIL rst_pre_out: valid %b result %0d want 1 and 4", out_valid, out_result); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        vectors++; if (out_result !== 32'd0) begin miscompares++; $display("FAIL rst_out_result: got %0d want 0", out_result); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_out_busy: got %b want 0", busy); end
        start = 1'b1; cfg_beats = BW'(3);
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1; in_a = 32'h05050505; in_b = 32'h05050505;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_accum_in_ready: got %b want 0", in_ready); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_accum_busy: got %b want 0", busy); end
        vectors++; if (out_ovf !== 1'b0 || out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_accum_out: ovf %b valid %b want 0 0", out_ovf, out_valid); end
        fill_random(2);
        e = model_dot(2, 0, 32, eo);
        e32 = e[31:0];
        run_op(2, 0, 0, 0, 0);
        vectors++; if (r_res !== e32) begin miscompares++; $display("FAIL rst_next_result: got %0d want %0d", $signed(r_res), $signed(e32)); end
    endtask

    task automatic test_back_to_back();
        longint e;
        bit eo;
        logic [31:0] e32;
        for (int op = 0; op < 2; op++) begin
            fill_random(6 - op);
            e = model_dot(6 - op, 0, 32, eo);
            e32 = e[31:0];
            run_op(6 - op, 0, 0, 0, 0);
            vectors++; if (r_accept != 6 - op) begin miscompares++; $display("FAIL b2b_accept_cycles: got %0d want %0d", r_accept, 6 - op); end
            vectors++; if (r_res !== e32) begin miscompares++; $display("FAIL b2b_result: got %0d want %0d", $signed(r_res), $signed(e32)); end
            vectors++; if (r_latency != 4) begin miscompares++; $display("FAIL b2b_latency: got %0d want 4", r_latency); end
        end
    endtask

    task automatic test_random();
        longint e, e16;
        bit eo, eo16;
        logic [31:0] e32;
        logic [15:0] e16v;
        int n;
        bit sat;
        for (int it = 0; it < 20; it++) begin
            n = $urandom_range(1, 8);
            sat = $urandom_range(0, 1);
            fill_random(n);
            e = model_dot(n, sat, 32, eo);
            e16 = model_dot(n, sat, 16, eo16);
            e32 = e[31:0];
            e16v = e16[15:0];
            run_op(n, sat, 2, $urandom_range(0, 3), 0);
            vectors++; if (r_res !== e32 || r_ovf !== eo) begin miscompares++; $display("FAIL rand32 it%0d: got %0d/%b want %0d/%b", it, $signed(r_res), r_ovf, $signed(e32), eo); end
            vectors++; if (r_res16 !== e16v || r_ovf16 !== eo16) begin miscompares++; $display("FAIL rand16 it%0d sat%0d: got %0d/%b want %0d/%b", it, sat, $signed(r_res16), r_ovf16, $signed(e16v), eo16); end
            vectors++; if (r_latency != 4) begin miscompares++; $display("FAIL rand_latency it%0d: got %0d want 4", it, r_latency); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bubbles_backpressure();
        test_saturation();
        test_zero_beats();
        test_abort();
        test_reset_mid_op();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
